// File: rtl/horner_sequencer.sv
// Horner-scheme polynomial evaluation sequencer with batch, abort and busy/done.
// Optional cycle counter enabled by defining HORNER_PERF_CNT_EN.
module horner_sequencer #(
    parameter int ADDR_LINES  = 4,
    parameter int MAC_LATENCY = 10,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_LINES-1:0] wr_ptr_coeff,
    input  logic                  sig_full,
    input  logic                  coeff_full,
    input  logic [CNT_W-1:0]      batch_len,
    input  logic                  abort,
    output logic                  wr_en_signal,
    output logic                  wr_en_coeff,
    output logic                  rd_en_signal,
    output logic                  rd_en_coeff,
    output logic                  coeff_rewind,
    output logic                  acc_clr,
    output logic                  mac_en,
    output logic                  ld_result,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           cycle_count
);

    localparam int LAT_W = $clog2(MAC_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_STEP,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_LINES-1:0] r_order;
    logic [ADDR_LINES-1:0] r_order_cnt;
    logic [LAT_W-1:0]      r_lat_cnt;
    logic [CNT_W-1:0]      r_sample_cnt;
    logic [CNT_W-1:0]      r_blen;

    logic w_start;
    logic w_abort;
    logic w_last_lat;
    logic w_last_sample;
    logic w_order_zero;

    assign w_start       = sig_full & coeff_full & ~abort;
    assign w_abort       = abort & (r_state != S_IDLE);
    assign w_last_lat    = (r_lat_cnt == LAT_W'(MAC_LATENCY - 1));
    assign w_last_sample = (r_sample_cnt == (r_blen - CNT_W'(1)));
    assign w_order_zero  = (r_order_cnt == '0);
    assign busy          = (r_state != S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe decode; abort overrides everything
    always_comb begin
        w_next       = r_state;
        wr_en_signal = 1'b0;
        wr_en_coeff  = 1'b0;
        rd_en_signal = 1'b0;
        rd_en_coeff  = 1'b0;
        coeff_rewind = 1'b0;
        acc_clr      = 1'b0;
        mac_en       = 1'b0;
        ld_result    = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!sig_full) begin
                    wr_en_signal = 1'b1;
                end else if (!coeff_full) begin
                    wr_en_coeff = 1'b1;
                end
                if (w_start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                rd_en_signal = 1'b1;
                coeff_rewind = 1'b1;
                acc_clr      = 1'b1;
                w_next       = S_CHECK;
            end
            S_CHECK: begin
                if (w_order_zero) begin
                    ld_result = 1'b1;
                    w_next    = w_last_sample ? S_DONE : S_LOAD;
                end else begin
                    w_next = S_STEP;
                end
            end
            S_STEP: begin
                rd_en_coeff = 1'b1;
                mac_en      = 1'b1;
                w_next      = S_WAIT;
            end
            S_WAIT: begin
                if (w_last_lat) begin
                    w_next = S_CHECK;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_abort) begin
            rd_en_signal = 1'b0;
            rd_en_coeff  = 1'b0;
            coeff_rewind = 1'b0;
            acc_clr      = 1'b0;
            mac_en       = 1'b0;
            ld_result    = 1'b0;
            done         = 1'b0;
            w_next       = S_IDLE;
        end
    end

    // Order, batch length, and loop counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_order      <= '0;
            r_order_cnt  <= '0;
            r_lat_cnt    <= '0;
            r_sample_cnt <= '0;
            r_blen       <= '0;
        end else if (!w_abort) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_order      <= wr_ptr_coeff;
                        r_blen       <= (batch_len == '0) ? CNT_W'(1) : batch_len;
                        r_sample_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    r_order_cnt <= r_order;
                end
                S_CHECK: begin
                    if (w_order_zero && !w_last_sample) begin
                        r_sample_cnt <= r_sample_cnt + CNT_W'(1);
                    end
                end
                S_STEP: begin
                    r_order_cnt <= r_order_cnt - ADDR_LINES'(1);
                    r_lat_cnt   <= '0;
                end
                S_WAIT: begin
                    r_lat_cnt <= r_lat_cnt + LAT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef HORNER_PERF_CNT_EN
    logic [31:0] r_cycle_count;

    // Batch cycle counter: cleared at start, frozen while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_count <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_start) begin
                r_cycle_count <= '0;
            end
        end else begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`else
    assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_horner_sequencer.sv
// Directed self-checking bench for horner_sequencer.
// Runs a MAC_LATENCY=10 instance and a MAC_LATENCY=1 instance side by side.
module tb_horner_sequencer;

`ifdef HORNER_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  wr_ptr_coeff;
    logic        sig_full;
    logic        coeff_full;
    logic [7:0]  batch_len;
    logic        abort;

    logic a_wr_en_signal, a_wr_en_coeff, a_rd_en_signal, a_rd_en_coeff;
    logic a_coeff_rewind, a_acc_clr, a_mac_en, a_ld_result, a_busy, a_done;
    logic [31:0] a_cycle_count;
    logic b_wr_en_signal, b_wr_en_coeff, b_rd_en_signal, b_rd_en_coeff;
    logic b_coeff_rewind, b_acc_clr, b_mac_en, b_ld_result, b_busy, b_done;
    logic [31:0] b_cycle_count;

    always #5 clk = ~clk;

    horner_sequencer #(.ADDR_LINES(4), .MAC_LATENCY(10), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .wr_ptr_coeff(wr_ptr_coeff),
        .sig_full(sig_full), .coeff_full(coeff_full),
        .batch_len(batch_len), .abort(abort),
        .wr_en_signal(a_wr_en_signal), .wr_en_coeff(a_wr_en_coeff),
        .rd_en_signal(a_rd_en_signal), .rd_en_coeff(a_rd_en_coeff),
        .coeff_rewind(a_coeff_rewind), .acc_clr(a_acc_clr),
        .mac_en(a_mac_en), .ld_result(a_ld_result),
        .busy(a_busy), .done(a_done), .cycle_count(a_cycle_count)
    );

    horner_sequencer #(.ADDR_LINES(4), .MAC_LATENCY(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .wr_ptr_coeff(wr_ptr_coeff),
        .sig_full(sig_full), .coeff_full(coeff_full),
        .batch_len(batch_len), .abort(abort),
        .wr_en_signal(b_wr_en_signal), .wr_en_coeff(b_wr_en_coeff),
        .rd_en_signal(b_rd_en_signal), .rd_en_coeff(b_rd_en_coeff),
        .coeff_rewind(b_coeff_rewind), .acc_clr(b_acc_clr),
        .mac_en(b_mac_en), .ld_result(b_ld_result),
        .busy(b_busy), .done(b_done), .cycle_count(b_cycle_count)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int n_rdc, n_mac, n_rds, n_ld, n_done;
    int l_ld, t_done, t_idle;
    int n_ld1, l_ld1, t_done1;
    int p_rdc[16];
    int p_ld[16];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Sample the current cycle as t=0, then n-1 further cycles
    task automatic observe(input int n);
        n_rdc = 0; n_mac = 0; n_rds = 0; n_ld = 0; n_done = 0;
        l_ld = -1; t_done = -1; t_idle = -1;
        n_ld1 = 0; l_ld1 = -1; t_done1 = -1;
        for (int k = 0; k < 16; k++) begin
            p_rdc[k] = -1;
            p_ld[k]  = -1;
        end
        for (int t = 0; t < n; t++) begin
            if (t > 0) tick();
            if (a_rd_en_coeff) begin
                if (n_rdc < 16) p_rdc[n_rdc] = t;
                n_rdc++;
            end
            if (a_mac_en) n_mac++;
            if (a_rd_en_signal) n_rds++;
            if (a_ld_result) begin
                if (n_ld < 16) p_ld[n_ld] = t;
                n_ld++;
                l_ld = t;
            end
            if (a_done) begin
                n_done++;
                t_done = t;
            end
            if (!a_busy && t_idle < 0 && t > 0) t_idle = t;
            if (b_ld_result) begin
                n_ld1++;
                l_ld1 = t;
            end
            if (b_done) t_done1 = t;
            if (t == 0) begin
                sig_full   = 1'b0;
                coeff_full = 1'b0;
            end
        end
    endtask

    task automatic start();
        sig_full   = 1'b1;
        coeff_full = 1'b1;
        tick();
    endtask

    initial begin
        rst          = 1'b1;
        sig_full     = 1'b0;
        coeff_full   = 1'b0;
        abort        = 1'b0;
        wr_ptr_coeff = 4'd3;
        batch_len    = 8'd1;
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_cycle_count", a_cycle_count, 0);
        chk("rst_rd_en_signal", a_rd_en_signal, 0);
        chk("rst_ld_result", a_ld_result, 0);
        chk("fill_wr_en_signal", a_wr_en_signal, 1);
        chk("fill_wr_en_coeff", a_wr_en_coeff, 0);
        tick();
        sig_full = 1'b1;
        #1;
        chk("fill2_wr_en_signal", a_wr_en_signal, 0);
        chk("fill2_wr_en_coeff", a_wr_en_coeff, 1);
        coeff_full = 1'b1;
        #1;
        chk("fill3_wr_en_coeff", a_wr_en_coeff, 0);
        chk("fill3_busy", a_busy, 0);
        tick();
        chk("load_rd_en_signal", a_rd_en_signal, 1);
        chk("load_coeff_rewind", a_coeff_rewind, 1);
        chk("load_acc_clr", a_acc_clr, 1);
        chk("load_busy", a_busy, 1);

        // order 3, one sample
        observe(45);
        chk("o3_rdc_count", n_rdc, 3);
        chk("o3_mac_count", n_mac, 3);
        chk("o3_first_rdc", p_rdc[0], 2);
        chk("o3_rdc_gap1", p_rdc[1] - p_rdc[0], 12);
        chk("o3_rdc_gap2", p_rdc[2] - p_rdc[1], 12);
        chk("o3_ld_count", n_ld, 1);
        chk("o3_ld_time", l_ld, 37);
        chk("o3_done_count", n_done, 1);
        chk("o3_done_time", t_done, 38);
        chk("o3_busy_drop", t_idle, 39);
        chk("o3_cycle_count", a_cycle_count, PERF ? 39 : 0);
        chk("o3_lat1_ld_time", l_ld1, 10);
        chk("o3_lat1_done_time", t_done1, 11);
        chk("o3_lat1_cycle_count", b_cycle_count, PERF ? 12 : 0);

        // order 0, batch of 4
        wr_ptr_coeff = 4'd0;
        batch_len    = 8'd4;
        start();
        observe(12);
        chk("o0_rds_count", n_rds, 4);
        chk("o0_ld_count", n_ld, 4);
        chk("o0_ld_first", p_ld[0], 1);
        chk("o0_ld_third", p_ld[2], 5);
        chk("o0_ld_last", l_ld, 7);
        chk("o0_rdc_count", n_rdc, 0);
        chk("o0_done_time", t_done, 8);
        chk("o0_lat1_ld_count", n_ld1, 4);
        chk("o0_cycle_count", a_cycle_count, PERF ? 9 : 0);

        // batch_len 0 treated as 1; late input changes ignored
        wr_ptr_coeff = 4'd2;
        batch_len    = 8'd0;
        start();
        wr_ptr_coeff = 4'd5;
        batch_len    = 8'd3;
        observe(32);
        chk("b0_lat1_ld_count", n_ld1, 1);
        chk("b0_lat1_ld_time", l_ld1, 7);
        chk("b0_lat1_done_time", t_done1, 8);
        chk("b0_ld_count", n_ld, 1);
        chk("b0_ld_time", l_ld, 25);
        chk("b0_done_time", t_done, 26);
        chk("b0_rdc_count", n_rdc, 2);

        // abort during WAIT of sample 2 of 3
        wr_ptr_coeff = 4'd1;
        batch_len    = 8'd3;
        start();
        observe(21);
        chk("ab_ld_before", n_ld, 1);
        chk("ab_ld_time", l_ld, 13);
        abort = 1'b1;
        #1;
        chk("ab_cycle_busy", a_busy, 1);
        chk("ab_cycle_done", a_done, 0);
        tick();
        abort = 1'b0;
        chk("ab_next_busy", a_busy, 0);
        chk("ab_cycle_count", a_cycle_count, PERF ? 21 : 0);
        observe(30);
        chk("ab_after_ld", n_ld, 0);
        chk("ab_after_done", n_done, 0);
        chk("ab_after_rds", n_rds, 0);
        chk("ab_frozen_count", a_cycle_count, PERF ? 21 : 0);

        // abort in LOAD suppresses its strobes
        start();
        abort = 1'b1;
        #1;
        chk("abl_rd_en_signal", a_rd_en_signal, 0);
        chk("abl_acc_clr", a_acc_clr, 0);
        chk("abl_coeff_rewind", a_coeff_rewind, 0);
        tick();
        chk("abl_busy", a_busy, 0);
        sig_full   = 1'b0;
        coeff_full = 1'b0;
        abort      = 1'b0;
        chk("abl_cycle_count", a_cycle_count, PERF ? 1 : 0);

        // reset mid-STEP
        wr_ptr_coeff = 4'd2;
        batch_len    = 8'd1;
        tick();
        start();
        observe(3);
        chk("rs_step_rdc", a_rd_en_coeff, 1);
        chk("rs_step_mac", a_mac_en, 1);
        rst        = 1'b1;
        sig_full   = 1'b1;
        coeff_full = 1'b1;
        tick();
        chk("rs_rd_en_coeff", a_rd_en_coeff, 0);
        chk("rs_mac_en", a_mac_en, 0);
        chk("rs_rd_en_signal", a_rd_en_signal, 0);
        chk("rs_ld_result", a_ld_result, 0);
        chk("rs_done", a_done, 0);
        chk("rs_wr_en_signal", a_wr_en_signal, 0);
        chk("rs_wr_en_coeff", a_wr_en_coeff, 0);
        chk("rs_busy", a_busy, 0);
        chk("rs_cycle_count", a_cycle_count, 0);
        sig_full   = 1'b0;
        coeff_full = 1'b0;
        rst        = 1'b0;
        tick();
        chk("rs_idle_busy", a_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
